// File: rtl/wb_prefetch_pkg.sv
// Shared definitions for the Wishbone prefetch unit:
// fetch FSM encoding, word step and pointer-width helper.
package wb_prefetch_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_WORD_STEP  = WB_DATA_WIDTH / 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Bits needed to index `value` entries (value >= 2).
    function automatic int clog2b(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_prefetch_fifo.sv
// Synchronous {adr, data} FIFO for fetched words.
// Flush outranks push and pop; the head is read through a registered pointer.
module prefetch_fifo
    import wb_prefetch_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 4,
    localparam int PW         = clog2b(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic                  i_flush,
    input  logic [31:0]           i_push_adr,
    input  logic [DATA_WIDTH-1:0] i_push_dat,
    output logic [PW:0]           o_count,
    output logic [31:0]           o_head_adr,
    output logic [DATA_WIDTH-1:0] o_head_dat
);

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW:0]           r_count;
    logic [31:0]           r_adr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_dat_mem [DEPTH];

    logic w_pop;

    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_adr_mem[i] <= '0;
                r_dat_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_adr_mem[r_wr_ptr] <= i_push_adr;
                r_dat_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr            <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_count    = r_count;
    assign o_head_adr = r_adr_mem[r_rd_ptr];
    assign o_head_dat = r_dat_mem[r_rd_ptr];

endmodule

// File: rtl/wb_prefetch.sv
// Wishbone read master streaming sequential words into a prefetch FIFO,
// with redirect that flushes queued words and drops the one in flight.
module wb_prefetch
    import wb_prefetch_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADR  = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  redirect_i,
    input  logic [31:0]           redirect_adr_i,
    output logic [31:0]           adr_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i,
    output logic                  ins_valid_o,
    output logic [DATA_WIDTH-1:0] ins_data_o,
    output logic [31:0]           ins_adr_o,
    input  logic                  ins_ready_i
);

    localparam int             PW      = clog2b(DEPTH);
    localparam logic [31:0]    STEP    = 32'(DATA_WIDTH / 8);
    localparam logic [PW+1:0]  DEPTH_C = (PW + 2)'(DEPTH);

    state_e      r_state;
    state_e      w_state_nx;
    logic        r_in_flight;
    logic        r_discard;
    logic [31:0] r_adr;
    logic [31:0] r_req_adr;

    logic          w_stb;
    logic          w_push;
    logic          w_pop;
    logic [PW:0]   w_count;
    logic [PW+1:0] w_credit;

    // Credits use registered occupancy only, so a pop never reaches stb_o.
    assign w_credit = {1'b0, w_count} + {{(PW + 1){1'b0}}, r_in_flight};

    always_comb begin
        w_state_nx = r_state;
        w_stb      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (en_i) begin
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                w_stb = !redirect_i && (w_credit < DEPTH_C);
                if (!en_i) begin
                    w_state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_in_flight <= 1'b0;
            r_discard   <= 1'b0;
            r_adr       <= RESET_ADR;
            r_req_adr   <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_in_flight <= w_stb;
            r_discard   <= redirect_i && r_in_flight;
            if (redirect_i) begin
                r_adr <= redirect_adr_i;
            end else if (w_stb) begin
                r_adr <= r_adr + STEP;
            end
            if (w_stb) begin
                r_req_adr <= r_adr;
            end
        end
    end

    assign w_push = ack_i && r_in_flight && !r_discard;
    assign w_pop  = ins_valid_o && ins_ready_i && !redirect_i;

    prefetch_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_flush    (redirect_i),
        .i_push_adr (r_req_adr),
        .i_push_dat (dat_i),
        .o_count    (w_count),
        .o_head_adr (ins_adr_o),
        .o_head_dat (ins_data_o)
    );

    assign adr_o       = r_adr;
    assign stb_o       = w_stb;
    assign cyc_o       = w_stb || r_in_flight;
    assign ins_valid_o = (w_count != '0);

endmodule

// File: tb/tb_wb_prefetch.sv
// Scoreboard bench for wb_prefetch: 1-cycle ROM slave model, expected
// word stream rebuilt from the fetch address on every (re)start.
module tb_wb_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_adr_i = '0;
    logic [31:0] adr_o;
    logic        cyc_o;
    logic        stb_o;
    logic [31:0] dat_i = '0;
    logic        ack_i = 1'b0;
    logic        ins_valid_o;
    logic [31:0] ins_data_o;
    logic [31:0] ins_adr_o;
    logic        ins_ready_i = 1'b0;

    always #5 clk = ~clk;

    wb_prefetch #(
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_ADR  (32'h0000_0000)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .redirect_i     (redirect_i),
        .redirect_adr_i (redirect_adr_i),
        .adr_o          (adr_o),
        .cyc_o          (cyc_o),
        .stb_o          (stb_o),
        .dat_i          (dat_i),
        .ack_i          (ack_i),
        .ins_valid_o    (ins_valid_o),
        .ins_data_o     (ins_data_o),
        .ins_adr_o      (ins_adr_o),
        .ins_ready_i    (ins_ready_i)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_accepted = 0;
    logic [31:0] last_acc_adr = '0;
    logic [63:0] exp_q [$];
    logic [31:0] stb_log [$];
    logic [63:0] exp_word;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a >> 2) * 32'h1111_1111;
    endfunction

    // Ideal consumer-visible stream: consecutive words from address a.
    task automatic restart(input logic [31:0] a);
        logic [31:0] x;
        exp_q.delete();
        for (int i = 0; i < 512; i++) begin
            x = a + 32'(i) * 32'd4;
            exp_q.push_back({x, rom(x)});
        end
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slave: strobe accepted at an edge answers in the following cycle.
    always @(posedge clk) begin
        ack_i <= stb_o;
        dat_i <= rom(adr_o);
    end

    always @(negedge clk) begin
        if (!rst_i && stb_o) begin
            stb_log.push_back(adr_o);
        end
        if (!rst_i && !redirect_i && ins_valid_o && ins_ready_i) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL scoreboard: got %h/%h, nothing expected",
                         ins_adr_o, ins_data_o);
            end else begin
                exp_word = exp_q.pop_front();
                if ({ins_adr_o, ins_data_o} !== exp_word) begin
                    n_errors++;
                    $display("FAIL scoreboard: got %h/%h expected %h/%h",
                             ins_adr_o, ins_data_o,
                             exp_word[63:32], exp_word[31:0]);
                end
            end
            n_accepted++;
            last_acc_adr = ins_adr_o;
        end
    end

    int          lat;
    int          acc0;
    logic [31:0] wrap_exp [4];

    initial begin
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0004;

        repeat (3) tick();
        rst_i = 1'b0;
        restart(32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_idle", {29'b0, stb_o, cyc_o, ins_valid_o, adr_o},
                  64'h0);
            tick();
        end

        // Streaming from reset address.
        en_i = 1'b1;
        ins_ready_i = 1'b1;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ins_valid_o) begin
                lat = i;
                break;
            end
        end
        check("first_valid_latency", 64'(lat >= 2 && lat <= 3), 64'd1);
        check("first_word", {ins_adr_o, ins_data_o}, 64'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("throughput_valid", 64'(ins_valid_o), 64'd1);
        end
        tick();

        // Backpressure from a fresh start.
        ins_ready_i = 1'b0;
        redirect_i = 1'b1;
        redirect_adr_i = 32'h200;
        restart(32'h200);
        stb_log.delete();
        tick();
        redirect_i = 1'b0;
        repeat (12) tick();
        check("bp_strobes", 64'(stb_log.size()), 64'(DEPTH));
        check("bp_valid", 64'(ins_valid_o), 64'd1);
        ins_ready_i = 1'b1;
        tick();
        ins_ready_i = 1'b0;
        @(negedge clk);
        check("stb_after_pop", 64'(stb_o), 64'd1);
        tick();
        @(negedge clk);
        check("stb_full_again", 64'(stb_o), 64'd0);
        tick();
        acc0 = n_accepted;
        for (int i = 0; i < 300; i++) begin
            ins_ready_i = 1'($urandom_range(0, 1));
            tick();
        end
        check("bp_progress", 64'(n_accepted - acc0 >= 20), 64'd1);

        // Redirect while a response is in flight.
        ins_ready_i = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check("stream_busy", 64'(stb_o), 64'd1);
        @(posedge clk);
        #1;
        redirect_i = 1'b1;
        redirect_adr_i = 32'h100;
        restart(32'h100);
        tick();
        redirect_i = 1'b0;
        @(negedge clk);
        check("flushed", 64'(ins_valid_o), 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ins_valid_o) break;
        end
        check("redirect_word", {31'b0, ins_valid_o, ins_adr_o},
              {31'b0, 1'b1, 32'h100});
        check("redirect_data", 64'(ins_data_o), 64'h4444_4440);
        tick();

        // Address wrap.
        redirect_i = 1'b1;
        redirect_adr_i = 32'hFFFF_FFF8;
        restart(32'hFFFF_FFF8);
        stb_log.delete();
        tick();
        redirect_i = 1'b0;
        repeat (8) tick();
        check("wrap_count", 64'(stb_log.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (stb_log.size() > i) begin
                check("wrap_adr", 64'(stb_log[i]), 64'(wrap_exp[i]));
            end
        end

        // Disable in a strobe cycle.
        @(negedge clk);
        check("pre_disable_stb", 64'(stb_o), 64'd1);
        @(posedge clk);
        #1;
        en_i = 1'b0;
        stb_log.delete();
        repeat (6) tick();
        check("disable_strobes", 64'(stb_log.size()), 64'd1);
        if (stb_log.size() > 0) begin
            check("disable_captured", 64'(last_acc_adr), 64'(stb_log[0]));
        end
        check("disable_quiet", {62'b0, cyc_o, ins_valid_o}, 64'd0);

        // Reset with entries queued and a strobe outstanding.
        en_i = 1'b1;
        ins_ready_i = 1'b0;
        repeat (10) tick();
        ins_ready_i = 1'b1;
        tick();
        ins_ready_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        check("pre_reset_valid", 64'(ins_valid_o), 64'd1);
        tick();
        @(negedge clk);
        check("mid_reset_ctl", {29'b0, ins_valid_o, stb_o, cyc_o, adr_o},
              64'h0);
        check("mid_reset_head", {ins_adr_o, ins_data_o}, 64'h0);
        tick();
        rst_i = 1'b0;
        restart(32'h0);
        ins_ready_i = 1'b1;
        acc0 = n_accepted;
        repeat (30) tick();
        check("post_reset_stream", 64'(n_accepted - acc0 >= 20), 64'd1);

        en_i = 1'b0;
        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
